cdc_sync_bank: RTL and testbench
================================

Name: cdc_sync_bank

Overview:
- Parametrised destination-domain CDC receiver. Replaces the hand-placed double-flop paths and the clock-tied-off test path in earlier IP blocks.
- Provides CH independent single-bit synchronizers, each with an optional stability filter and edge detect.
- Provides one toggle-handshake bundled-data capture port, so a multi-bit bus can cross without per-bit synchronization.
- Sits at the boundary of every block that receives signals from a foreign clock domain.

Parameters:
- CH, 4, number of single-bit async channels (>=1)
- STAGES, 2, synchronizer depth in flops (>=2)
- FILT, 0, stable cycles required before sync_out updates; 0 = filter off
- DW, 8, bundled data width (>=1)

Ports:
- clk  in  1  destination clock; all state is on its rising edge
- rst  in  1  synchronous, active-high reset
- test_mode  in  1  1 = freeze all state (clock-enable hold; no clock gating)
- async_in  in  CH  asynchronous level inputs
- sync_out  out  CH  synchronized (and filtered) levels
- rise  out  CH  1-cycle pulse on 0->1 of sync_out
- fall  out  CH  1-cycle pulse on 1->0 of sync_out
- req_in  in  1  async toggle request from source domain
- data_in  in  DW  async data; source holds it stable from req toggle until ack observed
- data_out  out  DW  captured data
- data_valid  out  1  1-cycle pulse when data_out is updated
- ack_out  out  1  toggle acknowledge back to source
- proto_err  out  1  sticky: req edge arrived while capture still in progress

Behaviour:
- Reset (rst=1 at a clk edge) forces every flop to 0. This covers all sync stages, filter counters, sync_out, rise, fall, data_out, data_valid, ack_out, proto_err, req_last and the FSM (IDLE). rst overrides test_mode. A reset mid-capture abandons the transfer: no data_valid, ack_out=0.
- test_mode=1 (and rst=0): all flops hold their value. rise, fall and data_valid are forced to 0 on the following cycle and stay 0 while test_mode=1. On test_mode 1->0, operation resumes from the held state.
- Per-channel sync: async_in[i] passes through a STAGES-deep flop chain; the chain output is s[i].
- FILT=0: sync_out[i] <= s[i]. Latency from an async_in change to sync_out is STAGES+1 edges, with 1 extra edge of metastability uncertainty.
- FILT>0: a per-channel counter of width clog2(FILT+1).
  - Counter clears when s[i]==sync_out[i].
  - Otherwise it increments.
  - When it reaches FILT, sync_out[i] <= s[i] and the counter clears.
  - Any bounce back to sync_out[i] before FILT clears the counter, so pulses shorter than FILT cycles are suppressed.
- rise[i] = sync_out[i] & ~prev[i] and fall[i] = ~sync_out[i] & prev[i], both registered, so each pulses exactly 1 cycle after the sync_out change.
- Handshake: req_in passes through its own STAGES chain to give rs. An edge is rs != req_last.
  - FSM state IDLE: on edge, req_last <= rs and go to CAPT.
  - FSM state CAPT (1 cycle): data_out <= data_in, data_valid=1, ack_out toggles, go to IDLE.
  - data_in is sampled only in CAPT. Safety relies on the source protocol (data stable until ack), not on synchronizing data_in.
  - Latency from a req_in toggle to data_valid is STAGES+2 edges.
  - An edge detected while in CAPT sets proto_err, which stays set until rst. That edge is then consumed on return to IDLE.
  - Back-to-back legal transfers take at least 2 cycles each.
- No path from any async input to any output is combinational.

Decomposition:
- Shared package cdc_pkg:
  - FSM enum (IDLE, CAPT)
  - constant MIN_STAGES=2
  - clog2 helper function
- Sub-module cdc_sync_chain (params W, STAGES; ports clk, rst, en, d, q). Instantiated once per channel and once for req_in, so synthesis and CDC constraints attach to one cell.

Test Plan:
- Reset mid-activity: drive async_in=4'hF, assert rst 1 cycle -> next cycle sync_out, rise, fall, data_out, ack_out, proto_err all 0.
- Basic sync, STAGES=2, FILT=0: async_in[0] 0->1 -> sync_out[0]=1 after 3 edges; rise[0] high exactly 1 cycle; fall stays 0.
- Filter, FILT=4:
  - a 3-cycle high glitch on async_in[1] -> sync_out[1] stays 0, no rise.
  - a 6-cycle high -> sync_out[1]=1 at STAGES+4+1 edges.
- Handshake: data_in=8'hA5, toggle req_in -> data_valid 1 cycle at STAGES+2 edges; data_out=8'hA5; ack_out 0->1.
  - Second transfer 8'h3C -> ack_out 1->0; proto_err=0.
- Protocol violation: toggle req_in twice on consecutive clk edges -> proto_err=1 and remains 1 until rst.
- test_mode: assert test_mode during an async_in change -> sync_out frozen, no rise pulse; deassert -> change propagates normally.

Source files
------------

// File: rtl/cdc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_pkg : shared handshake FSM type, constants and clog2 helper for the CDC bank
// Rev 1.0
// ----------------------------------------------------------------------------
package cdc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAPT = 1'b1
  } hs_state_e;

  localparam int MIN_STAGES = 2;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_sync_chain : W-bit multi-flop synchronizer with synchronous clear and hold
// Rev 1.0
// ----------------------------------------------------------------------------
module cdc_sync_chain
  import cdc_pkg::*;
#(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // A depth below two gives no metastability settling time, so clamp it.
  localparam int N = (STAGES < MIN_STAGES) ? MIN_STAGES : STAGES;

  logic [W-1:0] chain_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) chain_q[i] <= '0;
    end else if (en) begin
      chain_q[0] <= d;
      for (int i = 1; i < N; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[N-1];

endmodule
`default_nettype wire

// File: rtl/cdc_sync_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdc_sync_bank : per-bit level synchronizers with filter/edge detect, plus a
//                 toggle-handshake bundled-data capture port
// Rev 1.0
// ----------------------------------------------------------------------------
module cdc_sync_bank
  import cdc_pkg::*;
#(
  parameter int CH     = 4,
  parameter int STAGES = 2,
  parameter int FILT   = 0,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          test_mode,
  input  logic [CH-1:0] async_in,
  output logic [CH-1:0] sync_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  input  logic          req_in,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          ack_out,
  output logic          proto_err
);

  logic          run;
  logic [CH-1:0] s;
  logic [CH-1:0] prev_q, rise_q, fall_q;

  assign run = ~test_mode;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    cdc_sync_chain #(.W(1), .STAGES(STAGES)) u_sync (
      .clk(clk), .rst(rst), .en(run), .d(async_in[i]), .q(s[i])
    );

    if (FILT == 0) begin : g_nofilt
      logic so_q;
      always_ff @(posedge clk) begin
        if (rst)      so_q <= 1'b0;
        else if (run) so_q <= s[i];
      end
      assign sync_out[i] = so_q;
    end else begin : g_filt
      localparam int CW = clog2(FILT + 1);
      logic          so_q, so_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Counter measures how long s has disagreed with the output level.
      always_comb begin
        cnt_d = cnt_q;
        so_d  = so_q;
        if (s[i] == so_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(FILT)) begin
          so_d  = s[i];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          so_q  <= 1'b0;
          cnt_q <= '0;
        end else if (run) begin
          so_q  <= so_d;
          cnt_q <= cnt_d;
        end
      end
      assign sync_out[i] = so_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else if (test_mode) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= sync_out;
      rise_q <= sync_out & ~prev_q;
      fall_q <= ~sync_out & prev_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

  logic          rs, req_edge;
  hs_state_e     state_q, state_d;
  logic          req_last_q, req_last_d;
  logic          ack_q, ack_d;
  logic          perr_q, perr_d;
  logic          dv_q, dv_d;
  logic [DW-1:0] data_q, data_d;

  cdc_sync_chain #(.W(1), .STAGES(STAGES)) u_req_sync (
    .clk(clk), .rst(rst), .en(run), .d(req_in), .q(rs)
  );

  assign req_edge = rs ^ req_last_q;

  // data_in is only sampled in CAPT; the source keeps it stable until ack.
  always_comb begin
    state_d    = state_q;
    req_last_d = req_last_q;
    ack_d      = ack_q;
    perr_d     = perr_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          req_last_d = rs;
          state_d    = CAPT;
        end
      end
      CAPT: begin
        data_d  = data_in;
        dv_d    = 1'b1;
        ack_d   = ~ack_q;
        state_d = IDLE;
        if (req_edge) begin
          perr_d     = 1'b1;
          req_last_d = rs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_last_q <= 1'b0;
      ack_q      <= 1'b0;
      perr_q     <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
    end else if (test_mode) begin
      dv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_last_q <= req_last_d;
      ack_q      <= ack_d;
      perr_q     <= perr_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign ack_out    = ack_q;
  assign proto_err  = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_sync_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cdc_sync_bank : scoreboard bench for cdc_sync_bank (FILT=0 and FILT=4 instances)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cdc_sync_bank;

  localparam int CH = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, test_mode, req_in, req_f;
  logic [CH-1:0] a0, af;
  logic [DW-1:0] din, din_f;

  logic [CH-1:0] sync0, rise0, fall0, syncf, risef, fallf;
  logic [DW-1:0] dout0, doutf;
  logic          dv0, ack0, perr0, dvf, ackf, perrf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int ch; bit up; int cyc; } edge_t;
  typedef struct { logic [DW-1:0] d; logic ack; int cyc; } dv_t;

  edge_t q0[$];
  edge_t qf[$];
  dv_t   qd[$];

  cdc_sync_bank #(.CH(CH), .STAGES(2), .FILT(0), .DW(DW)) dut0 (
    .clk(clk), .rst(rst), .test_mode(test_mode),
    .async_in(a0), .sync_out(sync0), .rise(rise0), .fall(fall0),
    .req_in(req_in), .data_in(din), .data_out(dout0),
    .data_valid(dv0), .ack_out(ack0), .proto_err(perr0)
  );

  cdc_sync_bank #(.CH(CH), .STAGES(2), .FILT(4), .DW(DW)) dut_f (
    .clk(clk), .rst(rst), .test_mode(test_mode),
    .async_in(af), .sync_out(syncf), .rise(risef), .fall(fallf),
    .req_in(req_f), .data_in(din_f), .data_out(doutf),
    .data_valid(dvf), .ack_out(ackf), .proto_err(perrf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon_edge(input int which, input int ch, input bit up);
    edge_t e;
    checks++;
    if ((which == 0 && q0.size() == 0) || (which == 1 && qf.size() == 0)) begin
      errors++;
      $display("FAIL edge_unexpected dut=%0d ch=%0d rise=%0b cyc=%0d (none expected)",
               which, ch, up, cyc);
      return;
    end
    if (which == 0) e = q0.pop_front();
    else            e = qf.pop_front();
    if (e.ch != ch || e.up != up || e.cyc != cyc) begin
      errors++;
      $display("FAIL edge_event dut=%0d actual ch=%0d rise=%0b cyc=%0d expected ch=%0d rise=%0b cyc=%0d",
               which, ch, up, cyc, e.ch, e.up, e.cyc);
    end
  endtask

  task automatic mon_dv();
    dv_t e;
    checks++;
    if (qd.size() == 0) begin
      errors++;
      $display("FAIL dv_unexpected data=%0h ack=%0b cyc=%0d (none expected)", dout0, ack0, cyc);
      return;
    end
    e = qd.pop_front();
    if (dout0 !== e.d || ack0 !== e.ack || cyc != e.cyc) begin
      errors++;
      $display("FAIL dv_event actual data=%0h ack=%0b cyc=%0d expected data=%0h ack=%0b cyc=%0d",
               dout0, ack0, cyc, e.d, e.ack, e.cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (rise0[i]) mon_edge(0, i, 1'b1);
      if (fall0[i]) mon_edge(0, i, 1'b0);
      if (risef[i]) mon_edge(1, i, 1'b1);
      if (fallf[i]) mon_edge(1, i, 1'b0);
    end
    if (dv0) mon_dv();
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; test_mode = 1'b0; req_in = 1'b0; req_f = 1'b0;
    a0 = '0; af = '0; din = '0; din_f = '0;
    tick(2);
    chk("reset_sync_out", sync0, 0);
    chk("reset_edges", {rise0, fall0}, 0);
    chk("reset_ctrl", {dv0, ack0, perr0}, 0);
    chk("reset_data_out", dout0, 0);
    rst = 1'b0;

    // Reset mid-activity: level change and capture both in flight.
    k = cyc; a0 = 4'hF; din = 8'h77; req_in = 1'b1;
    tick(3);
    chk("pre_reset_sync", sync0, 4'hF);
    rst = 1'b1; a0 = '0; req_in = 1'b0;
    tick(1);
    chk("midrst_sync_out", sync0, 0);
    chk("midrst_edges", {rise0, fall0}, 0);
    chk("midrst_ctrl", {dv0, ack0, perr0}, 0);
    chk("midrst_data_out", dout0, 0);
    rst = 1'b0;
    tick(6);

    // Basic sync, FILT=0: sync_out after 3 edges, rise one edge later.
    k = cyc; a0[0] = 1'b1; q0.push_back('{0, 1'b1, k + 4});
    tick(2); chk("sync_lat_2", sync0[0], 0);
    tick(1); chk("sync_lat_3", sync0[0], 1);
    tick(3);
    k = cyc; a0[0] = 1'b0; q0.push_back('{0, 1'b0, k + 4});
    tick(6);

    // Filter, FILT=4: 3-cycle glitch suppressed.
    af[1] = 1'b1; tick(3); af[1] = 1'b0;
    tick(10); chk("filt_glitch", syncf[1], 0);

    // Filter: 6-cycle pulse passes at STAGES+FILT+1 and falls back after the same filtering.
    k = cyc; af[1] = 1'b1;
    qf.push_back('{1, 1'b1, k + 8});
    qf.push_back('{1, 1'b0, k + 14});
    tick(6); chk("filt_before", syncf[1], 0); af[1] = 1'b0;
    tick(1); chk("filt_after", syncf[1], 1);
    tick(10);

    // Handshake: two legal transfers.
    din = 8'hA5; k = cyc; req_in = 1'b1; qd.push_back('{8'hA5, 1'b1, k + 4});
    tick(6);
    din = 8'h3C; k = cyc; req_in = 1'b0; qd.push_back('{8'h3C, 1'b0, k + 4});
    tick(6);
    chk("hs_perr_clean", perr0, 0);
    chk("hs_data_hold", dout0, 8'h3C);

    // Protocol violation: req toggled on consecutive edges.
    din = 8'h5A; k = cyc; req_in = 1'b1; qd.push_back('{8'h5A, 1'b1, k + 4});
    tick(1); req_in = 1'b0;
    tick(3); chk("perr_set", perr0, 1);
    tick(8); chk("perr_sticky", perr0, 1);

    // test_mode freezes the chain mid-propagation.
    k = cyc; a0[2] = 1'b1;
    tick(1); test_mode = 1'b1;
    tick(5); chk("tm_frozen", sync0[2], 0);
    test_mode = 1'b0; q0.push_back('{2, 1'b1, k + 9});
    tick(1); chk("tm_resume_7", sync0[2], 0);
    tick(1); chk("tm_resume_8", sync0[2], 1);
    tick(4);

    // Final reset clears sticky error and captured data.
    rst = 1'b1; a0 = '0;
    tick(1);
    chk("final_rst_perr", perr0, 0);
    chk("final_rst_data", dout0, 0);
    chk("final_rst_ack", ack0, 0);
    chk("final_rst_sync", sync0, 0);
    rst = 1'b0;
    tick(8);

    chk("q0_drained", q0.size(), 0);
    chk("qf_drained", qf.size(), 0);
    chk("qd_drained", qd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
